// File: rtl/dct_idct_seq.sv
// Block sequencer: buffers a pixel stream into ping-pong 64-sample banks and feeds phase-aligned blocks to dct_idct.
// Latency: xin is registered; out_* follow xin by LAT+1 cycles via a matched tag line.
// Backpressure: in_ready drops only while the write bank is still full (both banks awaiting drain).
module dct_idct_seq #(
    parameter int LAT       = 150,
    parameter int PHASE_OFS = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  xin,
    input  logic [7:0]  pix_in,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_first,
    output logic        out_last,
    output logic [15:0] blk_cnt
);
    localparam logic [5:0] OFS = 6'(PHASE_OFS);

    logic [5:0] phase;
    logic       wbank;
    logic       rbank;
    logic [5:0] widx;
    logic [1:0] full;
    logic [1:0] full_nxt;
    logic       slot_data;
    logic [7:0] mem [2][64];
    logic [2:0] tag_x;
    logic [2:0] tag_sr [LAT];

    // Read index of the sample loaded into xin at the coming edge. Fetching
    // runs one cycle ahead of xin so sample 0 is on xin when phase==PHASE_OFS,
    // and the drained bank is released one edge before the next slot decision.
    logic [5:0] rk;
    logic       fetch_data;
    logic       wr_en;
    logic       wr_done;
    logic       rd_done;
    logic [2:0] tag_out;

    assign rk         = phase + 6'd1 - OFS;
    // Slot type is latched only at slot start from the registered full flag.
    assign fetch_data = (rk == 6'd0) ? full[rbank] : slot_data;
    assign in_ready   = ~RST & ~full[wbank];
    assign wr_en      = in_valid & in_ready;
    assign wr_done    = wr_en & (widx == 6'd63);
    assign rd_done    = fetch_data & (rk == 6'd63);
    assign tag_out    = tag_sr[LAT-1];

    // Full-flag update: drain side clears, fill side sets (always different banks).
    always_comb begin
        full_nxt = full;
        if (rd_done) full_nxt[rbank] = 1'b0;
        if (wr_done) full_nxt[wbank] = 1'b1;
    end

    // Phase counter, bank pointers, write index and slot-type register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            phase     <= 6'd0;
            wbank     <= 1'b0;
            rbank     <= 1'b0;
            widx      <= 6'd0;
            full      <= 2'b00;
            slot_data <= 1'b0;
        end else begin
            phase <= phase + 6'd1;
            full  <= full_nxt;
            if (rk == 6'd0) slot_data <= full[rbank];
            if (wr_en) widx <= widx + 6'd1;
            if (wr_done) wbank <= ~wbank;
            if (rd_done) rbank <= ~rbank;
        end
    end

    // Sample storage; contents need no reset since full flags gate every read.
    always_ff @(posedge CLK) begin
        if (wr_en) mem[wbank][widx] <= in_data;
    end

    // xin register, tag line matched to pipeline latency, output register and block counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            xin       <= 8'd0;
            tag_x     <= 3'b000;
            for (int i = 0; i < LAT; i++) tag_sr[i] <= 3'b000;
            out_data  <= 8'd0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            blk_cnt   <= 16'd0;
        end else begin
            xin   <= fetch_data ? mem[rbank][rk] : 8'd0;
            tag_x <= {fetch_data, fetch_data & (rk == 6'd0), fetch_data & (rk == 6'd63)};
            tag_sr[0] <= tag_x;
            for (int i = 1; i < LAT; i++) tag_sr[i] <= tag_sr[i-1];
            out_data  <= pix_in;
            out_valid <= tag_out[2];
            out_first <= tag_out[1];
            out_last  <= tag_out[0];
            if (out_valid && out_last) blk_cnt <= blk_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_dct_idct_seq.sv
// Directed bench for dct_idct_seq with an identity pipeline model of depth LAT on pix_in.
// Every cycle after reset is logged at the falling edge; checks run against hand-derived cycle numbers.
// Cycle 0 is the first cycle after reset (phase 0); slots start at multiples of 64.
module tb_dct_idct_seq;
    localparam int LAT  = 100;
    localparam int NLOG = 640;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  xin;
    logic [7:0]  pix_in;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_first;
    logic        out_last;
    logic [15:0] blk_cnt;

    dct_idct_seq #(.LAT(LAT), .PHASE_OFS(0)) dut (
        .CLK(CLK), .RST(RST),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .xin(xin), .pix_in(pix_in),
        .out_data(out_data), .out_valid(out_valid),
        .out_first(out_first), .out_last(out_last),
        .blk_cnt(blk_cnt)
    );

    always #5 CLK = ~CLK;

    // Identity stand-in for the transform pipeline: pix_in is xin delayed LAT cycles.
    logic [7:0] pipe [LAT];
    always @(posedge CLK) begin
        pipe[0] <= xin;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign pix_in = pipe[LAT-1];

    int cyc = 0;
    always @(posedge CLK) cyc <= RST ? 0 : cyc + 1;

    int lg_xin [NLOG];
    int lg_rdy [NLOG];
    int lg_acc [NLOG];
    int lg_ov  [NLOG];
    int lg_of  [NLOG];
    int lg_ol  [NLOG];
    int lg_od  [NLOG];
    int lg_bc  [NLOG];
    bit acc_s = 1'b0;

    // Per-cycle log of DUT pins, sampled mid-cycle.
    always @(negedge CLK) begin
        acc_s = in_valid && in_ready;
        if (!RST && cyc < NLOG) begin
            lg_xin[cyc] = int'(xin);
            lg_rdy[cyc] = int'(in_ready);
            lg_acc[cyc] = int'(in_valid && in_ready);
            lg_ov[cyc]  = int'(out_valid);
            lg_of[cyc]  = int'(out_first);
            lg_ol[cyc]  = int'(out_last);
            lg_od[cyc]  = int'(out_data);
            lg_bc[cyc]  = int'(blk_cnt);
        end
    end

    // Pixel source: offers pixel number 'sent' from cycle src_start until src_n accepted.
    int src_start = 1;
    int src_n     = 0;
    int src_mode  = 0;
    int sent      = 0;
    always begin
        @(posedge CLK);
        if (RST) sent = 0;
        else if (acc_s) sent = sent + 1;
        #1;
        in_valid = (cyc >= src_start) && (sent < src_n);
        case (src_mode)
            1:       in_data = 8'(sent / 64);
            2:       in_data = 8'(sent + 128);
            default: in_data = 8'(sent);
        endcase
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int cnt(input int which, input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) begin
            case (which)
                0: n += lg_ov[i];
                1: n += lg_of[i];
                2: n += lg_ol[i];
                3: n += (lg_xin[i] != 0) ? 1 : 0;
                4: n += lg_rdy[i];
                default: n += lg_acc[i];
            endcase
        end
        return n;
    endfunction

    // Advance until the log for cycle n is complete.
    task automatic run_to(input int n);
        int guard = 0;
        while (cyc < n && guard < 2000) begin
            @(negedge CLK);
            guard++;
        end
        if (cyc < n) chk("timeout", cyc, n);
        @(negedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST   = 1'b1;
        src_n = 0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rdy_in_rst", int'(in_ready), 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t expected finish", $time);
        $fatal(1);
    end

    initial begin
        // 1: one block 0..63 from cycle 1; FILL slot at 64, DATA slot at 128, out at 229..292.
        src_mode = 0; src_start = 1;
        do_reset();
        src_n = 64;
        run_to(0);
        chk("rst_xin", lg_xin[0], 0);
        chk("rst_ov",  lg_ov[0], 0);
        chk("rst_bc",  lg_bc[0], 0);
        chk("rst_rdy", lg_rdy[0], 1);
        run_to(300);
        chk("t1_acc", cnt(5, 0, 300), 64);
        chk("t1_fill_slot", cnt(3, 64, 127), 0);
        for (int k = 0; k < 64; k++) chk("t1_xin", lg_xin[128+k], k);
        chk("t1_ov_cnt", cnt(0, 0, 300), 64);
        chk("t1_ov_pre", lg_ov[228], 0);
        chk("t1_ov_start", lg_ov[229], 1);
        chk("t1_first", lg_of[229], 1);
        chk("t1_first_cnt", cnt(1, 0, 300), 1);
        chk("t1_last", lg_ol[292], 1);
        chk("t1_last_cnt", cnt(2, 0, 300), 1);
        for (int k = 0; k < 64; k++) chk("t1_od", lg_od[229+k], k);
        chk("t1_bc_pre", lg_bc[292], 0);
        chk("t1_bc", lg_bc[293], 1);

        // 2: idle source.
        do_reset();
        run_to(299);
        chk("t2_xin_nz", cnt(3, 0, 299), 0);
        chk("t2_ov", cnt(0, 0, 299), 0);
        chk("t2_bc", lg_bc[299], 0);
        chk("t2_rdy", cnt(4, 0, 299), 300);

        // 3: 200 pixels offered; both banks fill by cycle 128, bank 0 frees after read index 63 at 190.
        src_mode = 0; src_start = 1;
        do_reset();
        src_n = 200;
        run_to(330);
        chk("t3_acc_stall", cnt(5, 0, 190), 128);
        chk("t3_rdy_128", lg_rdy[128], 1);
        chk("t3_rdy_low", cnt(4, 129, 190), 0);
        chk("t3_rdy_191", lg_rdy[191], 1);
        chk("t3_acc_all", cnt(5, 0, 330), 200);
        chk("t3_xin_192", lg_xin[192], 64);
        chk("t3_xin_255", lg_xin[255], 127);
        chk("t3_xin_256", lg_xin[256], 128);
        chk("t3_od_293", lg_od[293], 64);
        chk("t3_of_293", lg_of[293], 1);

        // 4: four blocks valued by block index, back-to-back DATA slots at 128/192/256/320.
        src_mode = 1; src_start = 1;
        do_reset();
        src_n = 256;
        run_to(500);
        chk("t4_xin_b1", lg_xin[197], 1);
        chk("t4_xin_b2", lg_xin[261], 2);
        chk("t4_xin_b3", lg_xin[325], 3);
        chk("t4_ov_win", cnt(0, 229, 484), 256);
        chk("t4_ov_all", cnt(0, 0, 500), 256);
        chk("t4_first_cnt", cnt(1, 0, 500), 4);
        for (int b = 0; b < 4; b++) begin
            chk("t4_od", lg_od[229 + 64*b + 37], b);
            chk("t4_of", lg_of[229 + 64*b], 1);
            chk("t4_ol", lg_ol[292 + 64*b], 1);
        end
        chk("t4_bc_pre", lg_bc[484], 3);
        chk("t4_bc", lg_bc[485], 4);

        // 5: bank 0 completes on the edge ending cycle 127 (slot decision); slot 128 stays FILL.
        src_mode = 2; src_start = 64;
        do_reset();
        src_n = 64;
        run_to(360);
        chk("t5_acc", cnt(5, 64, 127), 64);
        chk("t5_fill_slot", cnt(3, 128, 191), 0);
        chk("t5_xin_192", lg_xin[192], 128);
        chk("t5_xin_255", lg_xin[255], 191);
        chk("t5_ov_fillwin", cnt(0, 229, 292), 0);
        chk("t5_ov_293", lg_ov[293], 1);
        chk("t5_od_293", lg_od[293], 128);
        chk("t5_of_293", lg_of[293], 1);
        chk("t5_ol_356", lg_ol[356], 1);
        chk("t5_bc", lg_bc[357], 1);

        // 6: reset at xin sample 30 of block 3 while bank 0 holds 32 pixels.
        src_mode = 0; src_start = 1;
        do_reset();
        src_n = 288;
        run_to(350);
        chk("t6_xin_k30", lg_xin[350], 222);
        chk("t6_bc_pre", lg_bc[350], 1);
        chk("t6_acc_pre", cnt(5, 0, 349), 287);
        src_n = 64; src_mode = 2; src_start = 1;
        RST = 1'b1;
        #1;
        chk("t6_rdy_rst", int'(in_ready), 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        run_to(0);
        chk("t6_rst_xin", lg_xin[0], 0);
        chk("t6_rst_ov", lg_ov[0], 0);
        chk("t6_rst_of", lg_of[0], 0);
        chk("t6_rst_ol", lg_ol[0], 0);
        chk("t6_rst_bc", lg_bc[0], 0);
        chk("t6_rst_rdy", lg_rdy[0], 1);
        run_to(320);
        chk("t6_ov_abort", cnt(0, 0, 228), 0);
        chk("t6_ov_all", cnt(0, 0, 320), 64);
        chk("t6_xin_nz_early", cnt(3, 0, 127), 0);
        chk("t6_xin_128", lg_xin[128], 128);
        chk("t6_xin_191", lg_xin[191], 191);
        chk("t6_od_229", lg_od[229], 128);
        chk("t6_of_229", lg_of[229], 1);
        chk("t6_bc_pre", lg_bc[292], 0);
        chk("t6_bc", lg_bc[293], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
